// File: rtl/nrisc_pipe_pkg.sv
// Shared types and defaults for the NRISC issue-to-writeback forwarding pipe.
// Holds the default-width stage record and the load-readiness helper.
package nrisc_pipe_pkg;

   localparam int TAM_DEF      = 16;
   localparam int REG_AW_DEF   = 4;
   localparam int DEPTH_DEF    = 2;
   localparam int LOAD_LAT_DEF = 1;

   // Stage record at the default widths; the pipe builds the same layout at its own widths.
   typedef struct packed {
      logic                  valid;
      logic                  write;
      logic                  load;
      logic [REG_AW_DEF-1:0] rfd;
      logic [TAM_DEF-1:0]    data;
   } stage_t;

   // A stage's result can be forwarded unless it is a load whose data has not been captured yet.
   function automatic logic stage_rdy(input logic load, input int idx, input int load_lat);
      return ~load | (idx >= load_lat);
   endfunction

endpackage

// File: rtl/nrisc_fwd_match.sv
// Priority scan for one ALU operand: finds the youngest in-flight writer of src.
module nrisc_fwd_match
   import nrisc_pipe_pkg::*;
#(
   parameter int TAM    = TAM_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                         use_src,
   input  logic [REG_AW-1:0]            src,
   input  logic [DEPTH-1:0]             st_valid,
   input  logic [DEPTH-1:0]             st_write,
   input  logic [DEPTH-1:0]             st_rdy,
   input  logic [DEPTH-1:0][REG_AW-1:0] st_rfd,
   input  logic [DEPTH-1:0][TAM-1:0]    st_data,
   output logic                         hit,
   output logic                         rdy,
   output logic [TAM-1:0]               data
);

   // Walk oldest to youngest so the lowest-index match overwrites any older one.
   always_comb begin
      hit  = 1'b0;
      rdy  = 1'b0;
      data = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (use_src && st_valid[i] && st_write[i] && (st_rfd[i] == src)) begin
            hit  = 1'b1;
            rdy  = st_rdy[i];
            data = st_data[i];
         end
      end
   end

endmodule

// File: rtl/nrisc_fwd_pipe.sv
// NRISC issue-to-writeback tracker: DEPTH-stage result pipe with operand
// forwarding and load-use stall.
// Optional build macro NRISC_FWD_R0_ZERO_EN: register 0 reads as zero and is never written.
module nrisc_fwd_pipe
   import nrisc_pipe_pkg::*;
#(
   parameter int TAM      = TAM_DEF,
   parameter int REG_AW   = REG_AW_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int LOAD_LAT = LOAD_LAT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rf1,
   input  logic [REG_AW-1:0] id_rf2,
   input  logic              id_use_a,
   input  logic              id_use_b,
   input  logic [REG_AW-1:0] id_rfd,
   input  logic              id_write,
   input  logic              id_load,
   input  logic [TAM-1:0]    reg_a,
   input  logic [TAM-1:0]    reg_b,
   input  logic [TAM-1:0]    ex_result,
   input  logic [TAM-1:0]    mem_data,
   input  logic              flush,
   output logic [TAM-1:0]    opnd_a,
   output logic [TAM-1:0]    opnd_b,
   output logic              stall,
   output logic              wb_write,
   output logic [REG_AW-1:0] wb_rfd,
   output logic [TAM-1:0]    wb_data
);

   typedef struct packed {
      logic              valid;
      logic              write;
      logic              load;
      logic [REG_AW-1:0] rfd;
      logic [TAM-1:0]    data;
   } stage_w_t;

   stage_w_t st [DEPTH];

   logic [DEPTH-1:0]             st_valid;
   logic [DEPTH-1:0]             st_write;
   logic [DEPTH-1:0]             st_rdy;
   logic [DEPTH-1:0][REG_AW-1:0] st_rfd;
   logic [DEPTH-1:0][TAM-1:0]    st_data;

   logic           src_a_zero;
   logic           src_b_zero;
   logic           write_in;
   logic           hit_a;
   logic           hit_b;
   logic           rdy_a;
   logic           rdy_b;
   logic [TAM-1:0] data_a;
   logic [TAM-1:0] data_b;
   logic           stall_a;
   logic           stall_b;
   logic           issue;

`ifdef NRISC_FWD_R0_ZERO_EN
   assign src_a_zero = (id_rf1 == '0);
   assign src_b_zero = (id_rf2 == '0);
   assign write_in   = id_write & (id_rfd != '0);
`else
   assign src_a_zero = 1'b0;
   assign src_b_zero = 1'b0;
   assign write_in   = id_write;
`endif

   // Flatten the stage records into per-field vectors for the operand scanners.
   always_comb begin
      st_valid = '0;
      st_write = '0;
      st_rdy   = '0;
      st_rfd   = '0;
      st_data  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         st_valid[i] = st[i].valid;
         st_write[i] = st[i].write;
         st_rdy[i]   = stage_rdy(st[i].load, i, LOAD_LAT);
         st_rfd[i]   = st[i].rfd;
         st_data[i]  = st[i].data;
      end
   end

   nrisc_fwd_match #(.TAM(TAM), .REG_AW(REG_AW), .DEPTH(DEPTH)) u_match_a (
      .use_src  (id_use_a & ~src_a_zero),
      .src      (id_rf1),
      .st_valid (st_valid),
      .st_write (st_write),
      .st_rdy   (st_rdy),
      .st_rfd   (st_rfd),
      .st_data  (st_data),
      .hit      (hit_a),
      .rdy      (rdy_a),
      .data     (data_a)
   );

   nrisc_fwd_match #(.TAM(TAM), .REG_AW(REG_AW), .DEPTH(DEPTH)) u_match_b (
      .use_src  (id_use_b & ~src_b_zero),
      .src      (id_rf2),
      .st_valid (st_valid),
      .st_write (st_write),
      .st_rdy   (st_rdy),
      .st_rfd   (st_rfd),
      .st_data  (st_data),
      .hit      (hit_b),
      .rdy      (rdy_b),
      .data     (data_b)
   );

   assign stall_a = hit_a & ~rdy_a;
   assign stall_b = hit_b & ~rdy_b;
   assign stall   = id_valid & (stall_a | stall_b);
   assign issue   = id_valid & ~stall & ~flush;

   // Operand select: hardwired zero, then a ready forward, else the regfile value.
   always_comb begin
      if (id_use_a && src_a_zero)  opnd_a = '0;
      else if (hit_a && rdy_a)     opnd_a = data_a;
      else                         opnd_a = reg_a;

      if (id_use_b && src_b_zero)  opnd_b = '0;
      else if (hit_b && rdy_b)     opnd_b = data_b;
      else                         opnd_b = reg_b;
   end

   // Advance every stage each cycle; a load takes its memory data on entering stage LOAD_LAT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) st[i] <= '0;
      end else begin
         if (issue) begin
            st[0].valid <= 1'b1;
            st[0].write <= write_in;
            st[0].load  <= id_load;
            st[0].rfd   <= id_rfd;
            st[0].data  <= ex_result;
         end else begin
            st[0] <= '0;
         end
         for (int i = 1; i < DEPTH; i++) begin
            st[i] <= st[i-1];
            if ((i == LOAD_LAT) && st[i-1].valid && st[i-1].load) st[i].data <= mem_data;
         end
      end
   end

   assign wb_write = st[DEPTH-1].valid & st[DEPTH-1].write;
   assign wb_rfd   = st[DEPTH-1].rfd;
   assign wb_data  = st[DEPTH-1].data;

endmodule

// File: tb/tb_nrisc_fwd_pipe.sv
// Scoreboard bench for nrisc_fwd_pipe (DEPTH=2, LOAD_LAT=1).
// Honours NRISC_FWD_R0_ZERO_EN when the design is built with it.
module tb_nrisc_fwd_pipe;

   localparam int TAM    = 16;
   localparam int REG_AW = 4;
   localparam logic [15:0] A = 16'hA0A0;
   localparam logic [15:0] B = 16'hB0B0;

`ifdef NRISC_FWD_R0_ZERO_EN
   localparam logic        R0_WB  = 1'b0;
   localparam logic [15:0] R0_EXP = 16'h0000;
`else
   localparam logic        R0_WB  = 1'b1;
   localparam logic [15:0] R0_EXP = 16'h1234;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              id_valid;
   logic [REG_AW-1:0] id_rf1;
   logic [REG_AW-1:0] id_rf2;
   logic              id_use_a;
   logic              id_use_b;
   logic [REG_AW-1:0] id_rfd;
   logic              id_write;
   logic              id_load;
   logic [TAM-1:0]    reg_a;
   logic [TAM-1:0]    reg_b;
   logic [TAM-1:0]    ex_result;
   logic [TAM-1:0]    mem_data;
   logic              flush;
   logic [TAM-1:0]    opnd_a;
   logic [TAM-1:0]    opnd_b;
   logic              stall;
   logic              wb_write;
   logic [REG_AW-1:0] wb_rfd;
   logic [TAM-1:0]    wb_data;

   nrisc_fwd_pipe #(.TAM(TAM), .REG_AW(REG_AW), .DEPTH(2), .LOAD_LAT(1)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rf1(id_rf1), .id_rf2(id_rf2),
      .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rfd(id_rfd), .id_write(id_write),
      .id_load(id_load), .reg_a(reg_a), .reg_b(reg_b), .ex_result(ex_result),
      .mem_data(mem_data), .flush(flush), .opnd_a(opnd_a), .opnd_b(opnd_b),
      .stall(stall), .wb_write(wb_write), .wb_rfd(wb_rfd), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_v, v;
      logic [3:0]  rf1;  logic ua;
      logic [3:0]  rf2;  logic ub;
      logic [3:0]  rfd;  logic wr, ld;
      logic [15:0] ex, mem;
      logic        fl;
      logic [15:0] ra, rb, ea, eb;
      logic        es, wbe;
      logic [3:0]  wrfd;
      logic [15:0] wdat;
      string       name;
   } vec_t;

   typedef struct {
      logic [15:0] ea, eb;
      logic        es;
      string       name;
   } comb_exp_t;

   typedef struct {
      logic [3:0]  rfd;
      logic [15:0] data;
      int          cyc;
      string       name;
   } wb_exp_t;

   vec_t      vecs[$];
   comb_exp_t combq[$];
   wb_exp_t   wbq[$];
   int        cyc = 0;
   int        checks = 0;
   int        errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic vec_t mk(
      input logic rst_v, input logic v,
      input logic [3:0] rf1, input logic ua, input logic [3:0] rf2, input logic ub,
      input logic [3:0] rfd, input logic wr, input logic ld,
      input logic [15:0] ex, input logic [15:0] mem, input logic fl,
      input logic [15:0] ra, input logic [15:0] rb,
      input logic [15:0] ea, input logic [15:0] eb, input logic es,
      input logic wbe, input logic [3:0] wrfd, input logic [15:0] wdat, input string name);
      vec_t t;
      t.rst_v = rst_v; t.v = v; t.rf1 = rf1; t.ua = ua; t.rf2 = rf2; t.ub = ub;
      t.rfd = rfd; t.wr = wr; t.ld = ld; t.ex = ex; t.mem = mem; t.fl = fl;
      t.ra = ra; t.rb = rb; t.ea = ea; t.eb = eb; t.es = es;
      t.wbe = wbe; t.wrfd = wrfd; t.wdat = wdat; t.name = name;
      return t;
   endfunction

   // Monitor: compare combinational outputs each cycle and writebacks as they appear.
   always @(negedge clk) begin
      if (combq.size() > 0) begin
         comb_exp_t e;
         e = combq.pop_front();
         checks++;
         if (opnd_a !== e.ea) begin
            errors++;
            $display("FAIL %s opnd_a: got %h expected %h", e.name, opnd_a, e.ea);
         end
         checks++;
         if (opnd_b !== e.eb) begin
            errors++;
            $display("FAIL %s opnd_b: got %h expected %h", e.name, opnd_b, e.eb);
         end
         checks++;
         if (stall !== e.es) begin
            errors++;
            $display("FAIL %s stall: got %b expected %b", e.name, stall, e.es);
         end
      end
      if (rst === 1'b0) begin
         checks++;
         if (wb_write !== 1'b0 || wb_rfd !== '0 || wb_data !== '0) begin
            errors++;
            $display("FAIL reset_wb: got write=%b rfd=%h data=%h expected all zero",
                     wb_write, wb_rfd, wb_data);
         end
      end
      if (wbq.size() > 0 && wbq[0].cyc < cyc) begin
         wb_exp_t m;
         m = wbq.pop_front();
         checks++;
         errors++;
         $display("FAIL %s wb_missing: got no write at cycle %0d expected rfd=%h data=%h",
                  m.name, m.cyc, m.rfd, m.data);
      end
      if (wb_write === 1'b1) begin
         checks++;
         if (wbq.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected: got rfd=%h data=%h at cycle %0d expected no write",
                     wb_rfd, wb_data, cyc);
         end else begin
            wb_exp_t w;
            w = wbq.pop_front();
            if (wb_rfd !== w.rfd || wb_data !== w.data || cyc != w.cyc) begin
               errors++;
               $display("FAIL %s wb: got rfd=%h data=%h cycle %0d expected rfd=%h data=%h cycle %0d",
                        w.name, wb_rfd, wb_data, cyc, w.rfd, w.data, w.cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Driver: apply one vector per cycle just after the rising edge and post its expectations.
   initial begin
      rst = 1'b0; id_valid = 1'b0; id_rf1 = '0; id_rf2 = '0; id_use_a = 1'b0; id_use_b = 1'b0;
      id_rfd = '0; id_write = 1'b0; id_load = 1'b0; reg_a = A; reg_b = B;
      ex_result = '0; mem_data = '0; flush = 1'b0;

      vecs.push_back(mk(0,1, 2,1, 3,1, 1,1,0, 16'h0101,16'h0000,0, A,B, A,B,0, 0,0,16'h0000, "rst_issue0"));
      vecs.push_back(mk(0,1, 1,1, 1,1, 2,1,0, 16'h0202,16'h0000,0, A,B, A,B,0, 0,0,16'h0000, "rst_issue1"));
      vecs.push_back(mk(1,0, 0,0, 0,0, 0,0,0, 16'h0000,16'h0000,0, A,B, A,B,0, 0,0,16'h0000, "post_rst0"));
      vecs.push_back(mk(1,0, 0,0, 0,0, 0,0,0, 16'h0000,16'h0000,0, A,B, A,B,0, 0,0,16'h0000, "post_rst1"));
      vecs.push_back(mk(1,1, 0,0, 0,0, 3,1,0, 16'h0005,16'h0000,0, A,B, A,B,0, 1,3,16'h0005, "alu_issue"));
      vecs.push_back(mk(1,1, 3,1, 0,0, 6,0,0, 16'h0600,16'h0000,0, 16'h0000,B, 16'h0005,B,0, 0,0,16'h0000, "alu_fwd_s0"));
      vecs.push_back(mk(1,1, 3,1, 3,1, 6,0,0, 16'h0000,16'h0000,0, 16'h0000,16'h0000, 16'h0005,16'h0005,0, 0,0,16'h0000, "alu_fwd_wb"));
      vecs.push_back(mk(1,1, 0,0, 0,0, 4,1,1, 16'hDEAD,16'h0000,0, A,B, A,B,0, 1,4,16'hBEEF, "ld_issue"));
      vecs.push_back(mk(1,1, 4,1, 0,0, 8,1,0, 16'h0808,16'hBEEF,0, A,B, A,B,1, 0,0,16'h0000, "ld_use_stall"));
      vecs.push_back(mk(1,1, 4,1, 0,0, 8,1,0, 16'h0808,16'h0000,0, A,B, 16'hBEEF,B,0, 1,8,16'h0808, "ld_use_fwd"));
      vecs.push_back(mk(1,1, 0,0, 0,0, 2,1,0, 16'h0011,16'h0000,0, A,B, A,B,0, 1,2,16'h0011, "dw_first"));
      vecs.push_back(mk(1,1, 0,0, 0,0, 2,1,0, 16'h0022,16'h0000,0, A,B, A,B,0, 1,2,16'h0022, "dw_second"));
      vecs.push_back(mk(1,1, 0,0, 2,1, 0,0,0, 16'h0000,16'h0000,0, A,B, A,16'h0022,0, 0,0,16'h0000, "dw_reader"));
      vecs.push_back(mk(1,1, 0,0, 0,0, 5,1,0, 16'h0055,16'h0000,1, A,B, A,B,0, 0,0,16'h0000, "flush_issue"));
      vecs.push_back(mk(1,1, 5,1, 0,0, 0,0,0, 16'h0000,16'h0000,0, A,B, A,B,0, 0,0,16'h0000, "flush_rd0"));
      vecs.push_back(mk(1,1, 5,1, 0,0, 0,0,0, 16'h0000,16'h0000,0, A,B, A,B,0, 0,0,16'h0000, "flush_rd1"));
      vecs.push_back(mk(1,1, 0,0, 0,0, 9,1,1, 16'h0000,16'h0000,0, A,B, A,B,0, 1,9,16'h9999, "ld9_issue"));
      vecs.push_back(mk(1,1, 9,1, 0,0, 10,1,0, 16'h1010,16'h9999,1, A,B, A,B,1, 0,0,16'h0000, "flush_over_stall"));
      vecs.push_back(mk(1,1, 9,1, 0,0, 0,0,0, 16'h0000,16'h0000,0, A,B, 16'h9999,B,0, 0,0,16'h0000, "ld9_fwd"));
      vecs.push_back(mk(1,1, 0,0, 0,0, 7,1,0, 16'h0077,16'h0000,0, A,B, A,B,0, 0,0,16'h0000, "r7_issue"));
      vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 16'h0000,16'h0000,0, A,B, A,B,0, 0,0,16'h0000, "rst_mid"));
      vecs.push_back(mk(1,1, 7,1, 0,0, 0,0,0, 16'h0000,16'h0000,0, A,B, A,B,0, 0,0,16'h0000, "r7_dropped"));
      vecs.push_back(mk(1,0, 0,0, 0,0, 0,0,0, 16'h0000,16'h0000,0, A,B, A,B,0, 0,0,16'h0000, "idle"));
      vecs.push_back(mk(1,1, 0,0, 0,0, 0,1,0, 16'h1234,16'h0000,0, A,B, A,B,0, R0_WB,0,16'h1234, "r0_write"));
      vecs.push_back(mk(1,1, 0,1, 0,0, 0,0,0, 16'h0000,16'h0000,0, A,B, R0_EXP,B,0, 0,0,16'h0000, "r0_read"));

      foreach (vecs[k]) begin
         comb_exp_t ce;
         @(posedge clk);
         #1;
         rst       = vecs[k].rst_v;
         id_valid  = vecs[k].v;
         id_rf1    = vecs[k].rf1;
         id_use_a  = vecs[k].ua;
         id_rf2    = vecs[k].rf2;
         id_use_b  = vecs[k].ub;
         id_rfd    = vecs[k].rfd;
         id_write  = vecs[k].wr;
         id_load   = vecs[k].ld;
         ex_result = vecs[k].ex;
         mem_data  = vecs[k].mem;
         flush     = vecs[k].fl;
         reg_a     = vecs[k].ra;
         reg_b     = vecs[k].rb;
         ce.ea = vecs[k].ea; ce.eb = vecs[k].eb; ce.es = vecs[k].es; ce.name = vecs[k].name;
         combq.push_back(ce);
         if (vecs[k].wbe) begin
            wb_exp_t we;
            we.rfd = vecs[k].wrfd; we.data = vecs[k].wdat; we.cyc = cyc + 2; we.name = vecs[k].name;
            wbq.push_back(we);
         end
      end

      @(posedge clk);
      #1;
      id_valid = 1'b0; id_use_a = 1'b0; id_use_b = 1'b0; flush = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      checks++;
      if (wbq.size() != 0) begin
         errors++;
         $display("FAIL wb_drain: got %0d pending writebacks expected 0", wbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
